// File: rtl/store_narrow_pkg.sv
// Shared encodings and range-check helper for the store narrowing path.
package store_narrow_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_MG   = 3'd2,
    ST_WR   = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    return (size == 2'b11) || (size == SZ_HALF && lo[0]) || (size == SZ_WORD && lo != 2'b00);
  endfunction

  // Signed fits when all bits above the sign bit replicate it; unsigned fits when they are zero.
  function automatic logic range_ovf(input logic [31:0] d, input logic [1:0] size, input logic arith);
    logic r;
    r = 1'b0;
    case (size)
      SZ_BYTE: r = arith ? !((&d[31:7]) || !(|d[31:7])) : (|d[31:8]);
      SZ_HALF: r = arith ? !((&d[31:15]) || !(|d[31:15])) : (|d[31:16]);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/store_merge.sv
// Replaces the addressed byte/halfword lane of a word with narrowed store data.
module store_merge
  import store_narrow_pkg::*;
(
  input  logic [31:0] i_old,
  input  logic [31:0] i_data,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  output logic [31:0] o_word
);

  logic [31:0] w_word;

  always_comb begin
    w_word = i_old;
    case (i_size)
      SZ_BYTE: w_word[{i_addr_lo, 3'b000} +: 8]      = i_data[7:0];
      SZ_HALF: w_word[{i_addr_lo[1], 4'b0000} +: 16] = i_data[15:0];
      SZ_WORD: w_word                                = i_data;
      default: w_word                                = i_old;
    endcase
  end

  assign o_word = w_word;

endmodule

// File: rtl/store_narrow.sv
// Byte/halfword store via read-modify-write on a word-only memory; word stores write directly.
// Define STORE_OVF_CHECK_EN to build the narrow-width range check behind ovf (otherwise ovf=0).
module store_narrow
  import store_narrow_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  input  logic        req_arith,
  output logic        done,
  output logic        misalign,
  output logic        ovf,
  output logic [29:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_rdata,
  output logic        mem_wr,
  output logic [31:0] mem_wdata
);

  state_t      r_state;
  logic [29:0] r_addr;
  logic [1:0]  r_lo;
  logic [31:0] r_data;
  logic [1:0]  r_size;
  logic        r_ovf;
  logic [31:0] r_wdata;

  logic        w_mis;
  logic        w_ovf;
  logic [31:0] w_merged;

  assign w_mis = is_misaligned(req_size, req_addr[1:0]);

`ifdef STORE_OVF_CHECK_EN
  assign w_ovf = range_ovf(req_data, req_size, req_arith);
`else
  logic w_unused_arith;
  assign w_unused_arith = req_arith;
  assign w_ovf = 1'b0;
`endif

  store_merge u_merge (
    .i_old     (mem_rdata),
    .i_data    (r_data),
    .i_size    (r_size),
    .i_addr_lo (r_lo),
    .o_word    (w_merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_lo    <= '0;
      r_data  <= '0;
      r_size  <= '0;
      r_ovf   <= 1'b0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_addr <= req_addr[31:2];
            r_lo   <= req_addr[1:0];
            r_data <= req_data;
            r_size <= req_size;
            r_ovf  <= w_ovf & ~w_mis;
            if (w_mis) begin
              r_state <= ST_ERR;
            end else if (req_size == SZ_WORD) begin
              r_wdata <= req_data;
              r_state <= ST_WR;
            end else begin
              r_state <= ST_RD;
            end
          end
        end
        ST_RD:   r_state <= ST_MG;
        // mem_rdata is valid only in this state, one cycle after the read strobe.
        ST_MG: begin
          r_wdata <= w_merged;
          r_state <= ST_WR;
        end
        ST_WR:   r_state <= ST_IDLE;
        ST_ERR:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign mem_rd    = (r_state == ST_RD);
  assign mem_wr    = (r_state == ST_WR);
  assign done      = (r_state == ST_WR) || (r_state == ST_ERR);
  assign misalign  = (r_state == ST_ERR);
  assign ovf       = r_ovf & done;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_store_narrow.sv
// Bench for store_narrow: per-cycle compare against a transaction-level model plus literal pins.
module tb_store_narrow;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [1:0]  req_size = '0;
  logic        req_arith = 1'b0;
  logic        req_ready, done, misalign, ovf, mem_rd, mem_wr;
  logic [29:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem_wdata;

  store_narrow dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size), .req_arith(req_arith),
    .done(done), .misalign(misalign), .ovf(ovf), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .mem_wr(mem_wr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] preload(input int i);
    if (i == 'h40) return 32'h11223344;
    if (i == 'h80) return 32'hDEADBEEF;
    if (i == 'h41) return 32'h55667788;
    return (32'(i) * 32'h01010101) ^ 32'hA5A5A5A5;
  endfunction

  // Word-only memory: registered read, write on strobe.
  logic [31:0] mem [0:255];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = preload(i);
    forever begin
      @(posedge clk);
      if (mem_rd) mem_rdata <= mem[mem_addr[7:0]];
      if (mem_wr) mem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  typedef struct packed {
    logic        rd, wr, dn, mis, ov, rdy;
    logic [29:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mdl_mem [0:255];
  int          cyc = 0, acc_cyc = 0, rd_rel = -1, wr_rel = -1, done_rel = -1;
  logic [31:0] last_wdata = '0;
  logic        last_ovf = 1'b0, last_mis = 1'b0;

  // Expected per-cycle outputs of one accepted request, from the store rules directly.
  task automatic push_sched();
    exp_t e;
    logic [31:0] old, nw;
    logic signed [31:0] sd;
    logic ov;
    int k;
    e = '0;
    e.addr = req_addr[31:2];
    ov = 1'b0;
    sd = $signed(req_data);
    if (req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
        (req_size == 2'b10 && req_addr[1:0] != 2'b00)) begin
      e.dn = 1'b1; e.mis = 1'b1;
      q.push_back(e);
    end else if (req_size == 2'b10) begin
      e.wr = 1'b1; e.dn = 1'b1; e.wdata = req_data;
      q.push_back(e);
    end else begin
      old = mdl_mem[req_addr[9:2]];
      nw = old;
      if (req_size == 2'b00) begin
        k = int'(req_addr[1:0]);
        nw[8*k +: 8] = req_data[7:0];
`ifdef STORE_OVF_CHECK_EN
        ov = req_arith ? (sd < -128 || sd > 127) : (req_data > 255);
`endif
      end else begin
        k = int'(req_addr[1]);
        nw[16*k +: 16] = req_data[15:0];
`ifdef STORE_OVF_CHECK_EN
        ov = req_arith ? (sd < -32768 || sd > 32767) : (req_data > 65535);
`endif
      end
      e.rd = 1'b1;
      q.push_back(e);
      e.rd = 1'b0;
      q.push_back(e);
      e.wr = 1'b1; e.dn = 1'b1; e.ov = ov; e.wdata = nw;
      q.push_back(e);
    end
  endtask

  // Compare process: one expectation record per cycle, idle when nothing is outstanding.
  initial begin
    exp_t e;
    for (int i = 0; i < 256; i++) mdl_mem[i] = preload(i);
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        q.delete();
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
      end else begin
        if (q.size() > 0) e = q.pop_front();
        else begin e = '0; e.rdy = 1'b1; end
        chk("ready", 32'(req_ready), 32'(e.rdy));
        chk("mem_rd", 32'(mem_rd), 32'(e.rd));
        chk("mem_wr", 32'(mem_wr), 32'(e.wr));
        chk("done", 32'(done), 32'(e.dn));
        chk("misalign", 32'(misalign), 32'(e.mis));
        if (e.dn) chk("ovf", 32'(ovf), 32'(e.ov));
        if (!e.rdy) chk("mem_addr", 32'(mem_addr), 32'(e.addr));
        if (e.wr) begin
          chk("mem_wdata", mem_wdata, e.wdata);
          mdl_mem[e.addr[7:0]] = e.wdata;
        end
        if (mem_rd) rd_rel = cyc - acc_cyc;
        if (mem_wr) begin wr_rel = cyc - acc_cyc; last_wdata = mem_wdata; end
        if (done) begin done_rel = cyc - acc_cyc; last_ovf = ovf; last_mis = misalign; end
        if (req_valid && req_ready) begin
          acc_cyc = cyc; rd_rel = -1; wr_rel = -1; done_rel = -1;
          push_sched();
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                      input logic ar, input bit hold, output int waits);
    req_addr = a; req_data = d; req_size = s; req_arith = ar; req_valid = 1'b1;
    waits = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin waits = i; break; end
    end
    if (waits < 0) chk("accept_timeout", 32'd0, 32'd1);
    else begin @(posedge clk); #1; end
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (5) @(posedge clk);
    #1;
  endtask

  logic [31:0] tv_addr [5] = '{32'h101, 32'h102, 32'h102, 32'h200, 32'h200};
  logic [31:0] tv_data [5] = '{32'h180, 32'hFFFFFF80, 32'hFFFFFF7F, 32'h0001FFFF, 32'h00007FFF};
  logic [1:0]  tv_size [5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
  logic        tv_ar   [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    int w;
    logic exp_ovf_u;
`ifdef STORE_OVF_CHECK_EN
    exp_ovf_u = 1'b1;
`else
    exp_ovf_u = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    send(32'h103, 32'h000000AB, 2'b00, 1'b0, 0, w);
    settle();
    chk("byte_rd_cycle", 32'(rd_rel), 32'd1);
    chk("byte_wr_cycle", 32'(wr_rel), 32'd3);
    chk("byte_done_cycle", 32'(done_rel), 32'd3);
    chk("byte_wdata", last_wdata, 32'hAB223344);
    chk("byte_ovf", 32'(last_ovf), 32'd0);

    send(32'h202, 32'hFFFF8001, 2'b01, 1'b1, 0, w);
    settle();
    chk("half_s_wdata", last_wdata, 32'h8001BEEF);
    chk("half_s_ovf", 32'(last_ovf), 32'd0);

    send(32'h202, 32'hFFFF8001, 2'b01, 1'b0, 0, w);
    settle();
    chk("half_u_wdata", last_wdata, 32'h8001BEEF);
    chk("half_u_ovf", 32'(last_ovf), 32'(exp_ovf_u));

    send(32'h40, 32'h12345678, 2'b10, 1'b0, 0, w);
    settle();
    chk("word_wr_cycle", 32'(wr_rel), 32'd1);
    chk("word_no_rd", 32'(rd_rel), 32'hFFFFFFFF);
    chk("word_wdata", last_wdata, 32'h12345678);

    send(32'h301, 32'h5555, 2'b01, 1'b0, 0, w);
    settle();
    chk("mis_half_done_cycle", 32'(done_rel), 32'd1);
    chk("mis_half_flag", 32'(last_mis), 32'd1);
    chk("mis_half_no_wr", 32'(wr_rel), 32'hFFFFFFFF);

    send(32'h100, 32'h77, 2'b11, 1'b0, 0, w);
    settle();
    chk("mis_sz3_done_cycle", 32'(done_rel), 32'd1);
    chk("mis_sz3_no_rd", 32'(rd_rel), 32'hFFFFFFFF);

    for (int i = 0; i < 5; i++) begin
      send(tv_addr[i], tv_data[i], tv_size[i], tv_ar[i], 0, w);
      settle();
    end

    // Back-to-back: request held valid through completion is taken the cycle after done.
    send(32'hC0, 32'h11, 2'b00, 1'b0, 1, w);
    send(32'hC1, 32'h22, 2'b00, 1'b0, 0, w);
    chk("b2b_wait", 32'(w), 32'd3);
    settle();
    chk("b2b_mem", mem[8'h30], 32'h95952211);

    // Reset during the merge cycle abandons the store.
    send(32'h104, 32'h99, 2'b00, 1'b0, 0, w);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    settle();
    chk("rst_mid_mem", mem[8'h41], 32'h55667788);
    chk("rst_mid_ready", 32'(req_ready), 32'd1);

    send(32'h105, 32'h3C, 2'b00, 1'b0, 0, w);
    settle();
    chk("post_rst_wdata", last_wdata, 32'h55663C88);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
